// File: rtl/game_pkg.sv
// Shared types, defaults and the start tune for the game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPlay,
    StHit,
    StWin,
    StOver
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DefNumInv      = 128;
  localparam int unsigned DefStartLives  = 3;
  localparam int unsigned DefScoreDigits = 3;
  localparam int unsigned DefLrrBonus    = 10;
  localparam int unsigned DefTuneLen     = 8;
  localparam int unsigned DefNoteTicks   = 2;
  localparam int unsigned DefHitTicks    = 3;

  localparam int unsigned       PendW   = 8;
  localparam logic [PendW-1:0]  PendMax = 8'hFF;
  localparam int unsigned       TuneMax = 16;
  localparam int unsigned       CntW    = 8;

  // Element 0 is the first note played.
  localparam logic [TuneMax-1:0][3:0] TUNE = {
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd7, 4'd5, 4'd9, 4'd9, 4'd3, 4'd2, 4'd7, 4'd7
  };

  // Returns {carry, next digit}.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t d);
    return (d == 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// Pending-points queue that drains one point per clock into a saturating BCD score.
module bcd_score_acc
  import game_pkg::*;
#(
  parameter int unsigned DIGITS    = DefScoreDigits,
  parameter int unsigned LRR_BONUS = DefLrrBonus
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  add_inv_i,
  input  logic                  add_lrr_i,
  input  logic                  clr_i,
  output logic [DIGITS*4-1:0]   score_o
);

  localparam int unsigned SumW = PendW + 2;

  logic [PendW-1:0]    pending_q, pending_d;
  logic [DIGITS*4-1:0] score_q, score_d;
  logic [SumW-1:0]     sum;
  logic                drain, all_nines, carry;
  logic [4:0]          inc;

  assign drain = (pending_q != '0);

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[i*4 +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  always_comb begin
    sum = SumW'(pending_q) + SumW'(add_inv_i)
        + (add_lrr_i ? SumW'(LRR_BONUS) : '0) - SumW'(drain);
    pending_d = (sum > SumW'(PendMax)) ? PendMax : sum[PendW-1:0];

    score_d = score_q;
    carry   = 1'b1;
    inc     = '0;
    // A saturated score keeps draining pending without changing.
    if (drain && !all_nines) begin
      for (int i = 0; i < DIGITS; i++) begin
        inc = bcd_inc(score_q[i*4 +: 4]);
        if (carry) begin
          score_d[i*4 +: 4] = inc[3:0];
          carry             = inc[4];
        end
      end
    end

    if (clr_i) begin
      pending_d = '0;
      score_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q <= '0;
      score_q   <= '0;
    end else begin
      pending_q <= pending_d;
      score_q   <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Space Invaders game sequencer: state, lives, invaders left, score and start tune.
// Define CHEAT_EN to let the cheat input force a win while playing.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_INV      = DefNumInv,
  parameter int unsigned START_LIVES  = DefStartLives,
  parameter int unsigned SCORE_DIGITS = DefScoreDigits,
  parameter int unsigned LRR_BONUS    = DefLrrBonus,
  parameter int unsigned TUNE_LEN     = DefTuneLen,
  parameter int unsigned NOTE_TICKS   = DefNoteTicks,
  parameter int unsigned HIT_TICKS    = DefHitTicks
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           tick_i,
  input  logic                           spcKey_i,
  input  logic                           invHit_i,
  input  logic                           lrrHit_i,
  input  logic                           plrHit_i,
  input  logic                           cheat_i,
  output logic                           playEn_o,
  output logic                           objRst_o,
  output logic                           stgMsg_o,
  output logic                           winMsg_o,
  output logic                           edgMsg_o,
  output logic [SCORE_DIGITS*4-1:0]      scrNum_o,
  output logic [2:0]                     scrLiv_o,
  output logic [$clog2(NUM_INV+1)-1:0]   invLeft_o,
  output logic [3:0]                     sndOut_o
);

  localparam int unsigned InvW = $clog2(NUM_INV + 1);

  game_state_e      state_q, state_d;
  logic             key_q, key_rise;
  logic [4:0]       tune_idx_q, tune_idx_d;
  logic [CntW-1:0]  tick_cnt_q, tick_cnt_d;
  logic             hit_done_q, hit_done_d;
  logic [2:0]       lives_q, lives_d;
  logic [InvW-1:0]  inv_q, inv_d;
  logic [3:0]       snd_q, snd_d;
  logic             add_inv, add_lrr, clr_score;
  logic             cheat_win, win;

`ifdef CHEAT_EN
  assign cheat_win = cheat_i;
`else
  logic unused_cheat;
  assign unused_cheat = cheat_i;
  assign cheat_win    = 1'b0;
`endif

  assign key_rise = spcKey_i & ~key_q;

  always_comb begin
    state_d    = state_q;
    tune_idx_d = tune_idx_q;
    tick_cnt_d = tick_cnt_q;
    hit_done_d = hit_done_q;
    lives_d    = lives_q;
    inv_d      = inv_q;
    add_inv    = 1'b0;
    add_lrr    = 1'b0;
    clr_score  = 1'b0;
    win        = 1'b0;
    playEn_o   = 1'b0;
    objRst_o   = 1'b0;
    stgMsg_o   = 1'b0;
    winMsg_o   = 1'b0;
    edgMsg_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        stgMsg_o = 1'b1;
        if (tick_i && (tune_idx_q < 5'(TUNE_LEN))) begin
          if (tick_cnt_q == CntW'(NOTE_TICKS - 1)) begin
            tune_idx_d = tune_idx_q + 5'd1;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
        if (key_rise) state_d = StStart;
      end
      StStart: begin
        objRst_o   = 1'b1;
        clr_score  = 1'b1;
        lives_d    = 3'(START_LIVES);
        inv_d      = InvW'(NUM_INV);
        tick_cnt_d = '0;
        hit_done_d = 1'b0;
        state_d    = StPlay;
      end
      StPlay: begin
        playEn_o = 1'b1;
        add_inv  = invHit_i;
        add_lrr  = lrrHit_i;
        if (invHit_i && (inv_q != '0)) inv_d = inv_q - InvW'(1);
        // Clearing the wave outranks a simultaneous player hit.
        win = (invHit_i && (inv_q == InvW'(1))) || (inv_q == '0) || cheat_win;
        if (win) begin
          state_d = StWin;
        end else if (plrHit_i) begin
          state_d    = StHit;
          lives_d    = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          tick_cnt_d = '0;
          hit_done_d = 1'b0;
        end
      end
      StHit: begin
        if (lives_q == 3'd0) begin
          state_d = StOver;
        end else if (hit_done_q) begin
          objRst_o   = 1'b1;
          hit_done_d = 1'b0;
          state_d    = StPlay;
        end else if (tick_i) begin
          if (tick_cnt_q == CntW'(HIT_TICKS - 1)) begin
            hit_done_d = 1'b1;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
      end
      StWin, StOver: begin
        winMsg_o = (state_q == StWin);
        edgMsg_o = (state_q == StOver);
        if (key_rise) begin
          state_d    = StIdle;
          tune_idx_d = '0;
          tick_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so the note tracks the state the FSM is entering.
    snd_d = ((state_d == StIdle) && (tune_idx_d < 5'(TUNE_LEN))) ?
            TUNE[tune_idx_d[3:0]] : 4'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      key_q      <= 1'b0;
      tune_idx_q <= '0;
      tick_cnt_q <= '0;
      hit_done_q <= 1'b0;
      lives_q    <= 3'(START_LIVES);
      inv_q      <= InvW'(NUM_INV);
      snd_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      key_q      <= spcKey_i;
      tune_idx_q <= tune_idx_d;
      tick_cnt_q <= tick_cnt_d;
      hit_done_q <= hit_done_d;
      lives_q    <= lives_d;
      inv_q      <= inv_d;
      snd_q      <= snd_d;
    end
  end

  bcd_score_acc #(
    .DIGITS    (SCORE_DIGITS),
    .LRR_BONUS (LRR_BONUS)
  ) u_score (
    .clk       (clk),
    .resetN    (resetN),
    .add_inv_i (add_inv),
    .add_lrr_i (add_lrr),
    .clr_i     (clr_score),
    .score_o   (scrNum_o)
  );

  assign scrLiv_o  = lives_q;
  assign invLeft_o = inv_q;
  assign sndOut_o  = snd_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: default build plus a small-wave instance.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic resetN;
  logic tick, cheat;
  logic spc1, inv1, lrr1, plr1;
  logic spc2, inv2, lrr2, plr2;

  logic        playEn1, objRst1, stgMsg1, winMsg1, edgMsg1;
  logic [11:0] scrNum1;
  logic [2:0]  scrLiv1;
  logic [7:0]  invLeft1;
  logic [3:0]  sndOut1;

  logic        playEn2, objRst2, stgMsg2, winMsg2, edgMsg2;
  logic [7:0]  scrNum2;
  logic [2:0]  scrLiv2;
  logic [2:0]  invLeft2;
  logic [3:0]  sndOut2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_q[$];
  int unsigned tune_ref[8] = '{7, 7, 2, 3, 9, 9, 5, 7};

  always #5 clk = ~clk;

  game_flow_ctrl u_dut (
    .clk       (clk),
    .resetN    (resetN),
    .tick_i    (tick),
    .spcKey_i  (spc1),
    .invHit_i  (inv1),
    .lrrHit_i  (lrr1),
    .plrHit_i  (plr1),
    .cheat_i   (cheat),
    .playEn_o  (playEn1),
    .objRst_o  (objRst1),
    .stgMsg_o  (stgMsg1),
    .winMsg_o  (winMsg1),
    .edgMsg_o  (edgMsg1),
    .scrNum_o  (scrNum1),
    .scrLiv_o  (scrLiv1),
    .invLeft_o (invLeft1),
    .sndOut_o  (sndOut1)
  );

  game_flow_ctrl #(
    .NUM_INV      (4),
    .SCORE_DIGITS (2),
    .LRR_BONUS    (63)
  ) u_win (
    .clk       (clk),
    .resetN    (resetN),
    .tick_i    (tick),
    .spcKey_i  (spc2),
    .invHit_i  (inv2),
    .lrrHit_i  (lrr2),
    .plrHit_i  (plr2),
    .cheat_i   (cheat),
    .playEn_o  (playEn2),
    .objRst_o  (objRst2),
    .stgMsg_o  (stgMsg2),
    .winMsg_o  (winMsg2),
    .edgMsg_o  (edgMsg2),
    .scrNum_o  (scrNum2),
    .scrLiv_o  (scrLiv2),
    .invLeft_o (invLeft2),
    .sndOut_o  (sndOut2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input int unsigned v);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      check_eq(tag, act, exp_q.pop_front());
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned got;
    resetN = 1'b0;
    tick = 0; cheat = 0;
    spc1 = 0; inv1 = 0; lrr1 = 0; plr1 = 0;
    spc2 = 0; inv2 = 0; lrr2 = 0; plr2 = 0;
    cyc(3);

    // Reset state
    sb_push(0);   sb_pop_check("rst_snd", 32'(sndOut1));
    sb_push(3);   sb_pop_check("rst_liv", 32'(scrLiv1));
    sb_push(128); sb_pop_check("rst_inv", 32'(invLeft1));
    sb_push(0);   sb_pop_check("rst_scr", 32'(scrNum1));
    check_eq("rst_stg", 32'(stgMsg1), 1);
    check_eq("rst_play", 32'(playEn1), 0);
    check_eq("rst_objrst", 32'(objRst1), 0);
    check_eq("rst_win", 32'(winMsg1), 0);
    check_eq("rst_edg", 32'(edgMsg1), 0);

    resetN = 1'b1;
    cyc(1);

    // Start tune: note k/2 after k ticks, silent after the last note
    sb_push(tune_ref[0]);
    sb_pop_check("tune_0", 32'(sndOut1));
    for (int k = 1; k <= 17; k++) begin
      if (k / 2 < 8) sb_push(tune_ref[k/2]);
      else sb_push(0);
      pulse_tick();
      cyc(1);
      sb_pop_check($sformatf("tune_%0d", k), 32'(sndOut1));
      check_eq($sformatf("tune_stg_%0d", k), 32'(stgMsg1), 1);
    end

    // Start game
    spc1 = 1'b1;
    cyc(1);
    spc1 = 1'b0;
    check_eq("start_objrst", 32'(objRst1), 1);
    check_eq("start_snd", 32'(sndOut1), 0);
    cyc(1);
    check_eq("play_objrst", 32'(objRst1), 0);
    check_eq("play_en", 32'(playEn1), 1);
    check_eq("play_liv", 32'(scrLiv1), 3);
    check_eq("play_inv", 32'(invLeft1), 128);
    check_eq("play_scr", 32'(scrNum1), 0);

    // Invader and Lrrr kills
    for (int i = 0; i < 5; i++) begin
      inv1 = 1'b1; cyc(1); inv1 = 1'b0; cyc(1);
    end
    lrr1 = 1'b1; cyc(1); lrr1 = 1'b0;
    sb_push(123);
    sb_push(12'h015);
    cyc(15);
    sb_pop_check("kills_inv", 32'(invLeft1));
    sb_pop_check("kills_scr", 32'(scrNum1));

    // Three player hits
    for (int h = 0; h < 3; h++) begin
      sb_push(32'(2 - h));
      plr1 = 1'b1; cyc(1); plr1 = 1'b0;
      sb_pop_check($sformatf("hit%0d_liv", h), 32'(scrLiv1));
      check_eq($sformatf("hit%0d_play", h), 32'(playEn1), 0);
      if (h < 2) begin
        plr1 = 1'b1; cyc(1); plr1 = 1'b0;
        check_eq($sformatf("hit%0d_ignored", h), 32'(scrLiv1), 32'(2 - h));
        for (int j = 0; j < 3; j++) begin
          pulse_tick();
          if (j < 2) cyc(1);
        end
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
          if (objRst1) got = 1;
          else cyc(1);
        end
        check_eq($sformatf("hit%0d_objrst", h), got, 1);
        cyc(1);
        check_eq($sformatf("hit%0d_replay", h), 32'(playEn1), 1);
      end else begin
        cyc(1);
        check_eq("over_edg", 32'(edgMsg1), 1);
        check_eq("over_play", 32'(playEn1), 0);
        sb_push(12'h015);
        sb_pop_check("over_scr", 32'(scrNum1));
      end
    end

    spc1 = 1'b1; cyc(1); spc1 = 1'b0;
    check_eq("idle_stg", 32'(stgMsg1), 1);
    check_eq("idle_edg", 32'(edgMsg1), 0);
    check_eq("idle_snd", 32'(sndOut1), 7);

    // Small wave: bonus overflow and win over a simultaneous player hit
    spc2 = 1'b1; cyc(1); spc2 = 1'b0; cyc(1);
    check_eq("w_play", 32'(playEn2), 1);
    lrr2 = 1'b1; cyc(2); lrr2 = 1'b0;
    inv2 = 1'b1; cyc(3);
    plr2 = 1'b1; cyc(1);
    inv2 = 1'b0; plr2 = 1'b0;
    sb_push(1); sb_push(3); sb_push(0); sb_push(8'h99);
    sb_pop_check("w_winmsg", 32'(winMsg2));
    sb_pop_check("w_liv", 32'(scrLiv2));
    sb_pop_check("w_inv", 32'(invLeft2));
    check_eq("w_playen", 32'(playEn2), 0);
    cyc(200);
    sb_pop_check("w_scr_sat", 32'(scrNum2));
    check_eq("w_pending", 32'(u_win.u_score.pending_q), 0);

    // Reset mid-drain
    spc1 = 1'b1; cyc(1); spc1 = 1'b0; cyc(1);
    lrr1 = 1'b1; cyc(2); lrr1 = 1'b0;
    cyc(3);
    check_eq("drain_pre", 32'(scrNum1), 12'h004);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("mrst_scr", 32'(scrNum1), 0);
    check_eq("mrst_play", 32'(playEn1), 0);
    check_eq("mrst_objrst", 32'(objRst1), 0);
    check_eq("mrst_stg", 32'(stgMsg1), 1);
    check_eq("mrst_snd", 32'(sndOut1), 0);
    check_eq("mrst_liv", 32'(scrLiv1), 3);
    check_eq("mrst_inv", 32'(invLeft1), 128);
    check_eq("mrst_w_win", 32'(winMsg2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
